// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared types and widths for the two-requester shift arbiter
package shift_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int TAG_W  = 4;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// rtl/shift_arbiter_barrel_shifter.sv - combinational 32-bit left/right logical/arithmetic barrel shifter
module barrel_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    input  logic              arith,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = data;
        if (dir == SHIFT_LEFT) begin
            result = data << amt;
        end else if (arith) begin
            result = $unsigned($signed(data) >>> amt);
        end else begin
            result = data >> amt;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin two-requester front end to a registered barrel shifter
// Optional conflict counter enabled by defining SHIFT_ARB_PERF_EN.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int PRIO_INIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,
    input  logic              req0_arith,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,
    input  logic              req1_arith,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef SHIFT_ARB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic PRIO_INIT_BIT = (PRIO_INIT != 0);

    arb_state_t        state, state_nxt;
    logic              favour;
    logic              can_accept;
    logic              grant0, grant1;
    logic [DATA_W-1:0] op_data;
    logic [AMT_W-1:0]  op_amt;
    logic              op_dir;
    logic              op_arith;
    logic [TAG_W-1:0]  op_tag;
    logic              op_id;
    logic [DATA_W-1:0] shift_result;

    // A new operation can only be taken while idle or while the current result is being consumed.
    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            ST_IDLE:  can_accept = 1'b1;
            ST_SHIFT: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    can_accept = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (can_accept && rst_n) begin
            grant0 = req0_valid && (!req1_valid || !favour);
            grant1 = req1_valid && !grant0;
            if (grant0 || grant1) begin
                state_nxt = ST_SHIFT;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            favour   <= PRIO_INIT_BIT;
            op_data  <= '0;
            op_amt   <= '0;
            op_dir   <= SHIFT_LEFT;
            op_arith <= 1'b0;
            op_tag   <= '0;
            op_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0) begin
                favour   <= 1'b1;
                op_data  <= req0_data;
                op_amt   <= req0_amt;
                op_dir   <= req0_dir;
                op_arith <= req0_arith;
                op_tag   <= req0_tag;
                op_id    <= 1'b0;
            end else if (grant1) begin
                favour   <= 1'b0;
                op_data  <= req1_data;
                op_amt   <= req1_amt;
                op_dir   <= req1_dir;
                op_arith <= req1_arith;
                op_tag   <= req1_tag;
                op_id    <= 1'b1;
            end
        end
    end

    barrel_shifter u_shifter (
        .data   (op_data),
        .amt    (op_amt),
        .dir    (op_dir),
        .arith  (op_arith),
        .result (shift_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_tag   <= '0;
        end else if (state == ST_SHIFT) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shift_result;
            rsp_id    <= op_id;
            rsp_tag   <= op_tag;
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ARB_PERF_EN
    // At most one requester is granted per cycle, so both-valid always implies a loser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (req0_valid && req1_valid && !(grant0 && grant1)
                     && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic        req0_dir, req1_dir;
    logic        req0_arith, req1_arith;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
`ifdef SHIFT_ARB_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req0_arith (req0_arith),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .req1_arith (req1_arith),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag)
`ifdef SHIFT_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    task automatic clear_inputs();
        req0_valid = 0; req0_data = 0; req0_amt = 0; req0_dir = 0; req0_arith = 0; req0_tag = 0;
        req1_valid = 0; req1_data = 0; req1_amt = 0; req1_dir = 0; req1_arith = 0; req1_tag = 0;
        rsp_ready  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        req0_valid = 1;
        req1_valid = 1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_data} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_rsp: got v=%0b id=%0b tag=%h data=%h, want all zero", rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
        end
`ifdef SHIFT_ARB_PERF_EN
        n_cmp++;
        if (conflict_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_conflict: got %0d, want 0", conflict_cnt);
        end
`endif
        clear_inputs();
        rst_n = 1;
    endtask

    // One isolated operation: grant, in-flight operand corruption, response, consume.
    task automatic run_op(input bit id, input logic [31:0] data, input logic [4:0] amt,
                          input bit dir, input bit arith, input logic [3:0] tag,
                          input logic [31:0] exp_data, input string name);
        if (id == 0) begin
            req0_valid = 1; req0_data = data; req0_amt = amt; req0_dir = dir; req0_arith = arith; req0_tag = tag;
        end else begin
            req1_valid = 1; req1_data = data; req1_amt = amt; req1_dir = dir; req1_arith = arith; req1_tag = tag;
        end
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL %s grant: got ready1/0=%b, want %b", name, {req1_ready, req0_ready}, (id ? 2'b10 : 2'b01));
        end
        @(negedge clk);
        req0_data = ~data; req0_amt = ~amt; req0_dir = ~dir; req0_tag = ~tag;
        req1_data = ~data; req1_amt = ~amt; req1_dir = ~dir; req1_tag = ~tag;
        req0_valid = 0; req1_valid = 0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s shift_cycle: got rsp_valid=%b ready=%b, want 0 and 00", name, rsp_valid, {req1_ready, req0_ready});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== id || rsp_tag !== tag) begin
            n_bad++;
            $display("FAIL %s rsp: got v=%b data=%h id=%b tag=%h, want v=1 data=%h id=%b tag=%h",
                     name, rsp_valid, rsp_data, rsp_id, rsp_tag, exp_data, id, tag);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s consume: got rsp_valid=%b, want 0", name, rsp_valid);
        end
    endtask

    task automatic test_shifts();
        run_op(0, 32'h8000_0000, 5'd4,  1, 1, 4'h3, 32'hF800_0000, "arith_right");
        run_op(0, 32'hF0F0_F0F0, 5'd8,  0, 0, 4'h5, 32'hF0F0_F000, "left_single_req0");
        run_op(1, 32'h8000_0000, 5'd4,  1, 0, 4'h7, 32'h0800_0000, "logical_right");
        run_op(1, 32'h0000_0001, 5'd31, 0, 0, 4'h9, 32'h8000_0000, "left_31");
        run_op(1, 32'h1234_5678, 5'd0,  1, 1, 4'hC, 32'h1234_5678, "amt_zero");
        run_op(1, 32'h8000_0001, 5'd1,  0, 1, 4'hE, 32'h0000_0002, "left_arith_ignored");
        run_op(0, 32'h7FFF_FFFF, 5'd31, 1, 1, 4'h1, 32'h0000_0000, "arith_right_pos");
    endtask

    task automatic test_back_to_back();
        int ids[$];
        do_reset();
        req0_valid = 1; req0_data = 32'h0000_00F0; req0_amt = 4; req0_dir = 1; req0_tag = 4'h1;
        req1_valid = 1; req1_data = 32'h0000_000F; req1_amt = 4; req1_dir = 0; req1_tag = 4'h2;
        rsp_ready  = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                n_cmp++;
                if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL b2b_shift_cycle%0d: got v=%b ready=%b, want 0 and 00", c, rsp_valid, {req1_ready, req0_ready});
                end
            end else begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_data !== (rsp_id ? 32'h0000_00F0 : 32'h0000_000F)) begin
                    n_bad++;
                    $display("FAIL b2b_rsp%0d: got v=%b id=%b data=%h", c, rsp_valid, rsp_id, rsp_data);
                end
                ids.push_back(int'(rsp_id));
            end
        end
        n_cmp++;
        if (ids.size() != 4 || ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1) begin
            n_bad++;
            $display("FAIL b2b_order: got %p, want '{0,1,0,1}", ids);
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got rsp_valid=%b, want 0", rsp_valid);
        end
`ifdef SHIFT_ARB_PERF_EN
        n_cmp++;
        if (conflict_cnt !== 16'd8) begin
            n_bad++;
            $display("FAIL b2b_conflict: got %0d, want 8", conflict_cnt);
        end
`endif
    endtask

    task automatic test_stall_and_reset();
        req0_valid = 1; req0_data = 32'h0000_FF00; req0_amt = 4; req0_dir = 1; req0_arith = 0; req0_tag = 4'hA;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        req1_valid = 1; req1_data = 32'h0000_0003; req1_amt = 2; req1_dir = 0; req1_tag = 4'h6;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0FF0 || rsp_id !== 1'b0 || rsp_tag !== 4'hA
                || {req1_ready, req0_ready} !== 2'b00) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got v=%b data=%h id=%b tag=%h ready=%b", c, rsp_valid, rsp_data, rsp_id, rsp_tag, {req1_ready, req0_ready});
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL stall_release_grant: got %b, want 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 0;
        rsp_ready = 0;
        rst_n = 0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            n_bad++;
            $display("FAIL midop_reset: got v=%b data=%h, want 0/0", rsp_valid, rsp_data);
        end
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midop_dropped%0d: got rsp_valid=%b, want 0", c, rsp_valid);
            end
        end
`ifdef SHIFT_ARB_PERF_EN
        n_cmp++;
        if (conflict_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL midop_conflict: got %0d, want 0", conflict_cnt);
        end
`endif
        rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_back_to_back();
        test_stall_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
